// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
// Optional feature macro used by muldiv_unit: MULDIV_EARLY_OUT_EN.
package muldiv_pkg;

   localparam int unsigned MD_WIDTH = 32;

   typedef enum logic [2:0] {
      OP_MULT  = 3'b000,
      OP_MULTU = 3'b001,
      OP_DIV   = 3'b010,
      OP_DIVU  = 3'b011,
      OP_MTHI  = 3'b100,
      OP_MTLO  = 3'b101
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } md_state_e;

   // Quotient written to LO on a divide by zero
   localparam logic [MD_WIDTH-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/muldiv_abs.sv
// Two's-complement magnitude with sign flag; invert_i forces a negation so the
// same block can re-sign results after the iteration phase.
module muldiv_abs #(
   parameter int unsigned W = 32
) (
   input  logic [W-1:0] val_i,
   input  logic         signed_i,
   input  logic         invert_i,
   output logic [W-1:0] res_c_o,
   output logic         neg_c_o
);

   assign neg_c_o = signed_i & val_i[W-1];
   assign res_c_o = (neg_c_o ^ invert_i) ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply (radix-2 shift-add) and restoring divide unit.
// Define MULDIV_EARLY_OUT_EN to let multiplies stop once the multiplier is exhausted.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = MD_WIDTH
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] rs_val_i,
   input  logic [WIDTH-1:0] rt_val_i,
   input  logic             abort_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam int unsigned PW    = 2 * WIDTH;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   md_state_e        state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q, done_q;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic             is_div_q, div0_q, neg_res_q, neg_rem_q;
   logic [WIDTH-1:0] rs_q;
   logic [PW-1:0]    acc_q;      // MUL: product; DIV: {remainder, dividend/quotient}
   logic [PW-1:0]    mcand_q;    // MUL: shifted multiplicand; DIV: divisor in low half
   logic [WIDTH-1:0] mplier_q;

   logic             in_fix;
   logic [WIDTH-1:0] a_val, b_val, a_res, b_res;
   logic             a_sgn, a_inv, b_inv, a_neg, b_neg;
   logic [WIDTH:0]   rem_shift, rem_diff;
   logic [PW-1:0]    div_step, mul_step;
   logic             calc_last;
   logic [WIDTH-1:0] mul_hi_fix;

   // Operand conditioning in IDLE, result re-signing in FIX
   always_comb begin
      in_fix = (state_q == ST_FIX);
      a_val  = rs_val_i;
      b_val  = rt_val_i;
      if (in_fix) begin
         a_val = is_div_q ? acc_q[WIDTH-1:0]  : acc_q[PW-1:WIDTH];
         b_val = is_div_q ? acc_q[PW-1:WIDTH] : acc_q[WIDTH-1:0];
      end
      a_sgn = ~in_fix & ~op_i[0];
      a_inv = in_fix & neg_res_q;
      b_inv = in_fix & (is_div_q ? neg_rem_q : neg_res_q);
   end

   muldiv_abs #(.W(WIDTH)) u_abs_a (
      .val_i    (a_val),
      .signed_i (a_sgn),
      .invert_i (a_inv),
      .res_c_o  (a_res),
      .neg_c_o  (a_neg)
   );

   muldiv_abs #(.W(WIDTH)) u_abs_b (
      .val_i    (b_val),
      .signed_i (a_sgn),
      .invert_i (b_inv),
      .res_c_o  (b_res),
      .neg_c_o  (b_neg)
   );

   // One iteration of each algorithm, plus the high-word borrow fix for a negated product
   always_comb begin
      rem_shift = {acc_q[PW-1:WIDTH], acc_q[WIDTH-1]};
      rem_diff  = rem_shift - {1'b0, mcand_q[WIDTH-1:0]};
      if (rem_diff[WIDTH])
         div_step = {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      else
         div_step = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      mul_step   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
      mul_hi_fix = (neg_res_q && (acc_q[WIDTH-1:0] != '0)) ? ~acc_q[PW-1:WIDTH] : a_res;
`ifdef MULDIV_EARLY_OUT_EN
      calc_last = (cnt_q == CNT_LAST) || (!is_div_q && (mplier_q[WIDTH-1:1] == '0));
`else
      calc_last = (cnt_q == CNT_LAST);
`endif
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         is_div_q  <= 1'b0;
         div0_q    <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         rs_q      <= '0;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (start_i && !abort_i) begin
                  case (op_i)
                     OP_MTHI: begin
                        hi_q   <= rs_val_i;
                        done_q <= 1'b1;
                     end
                     OP_MTLO: begin
                        lo_q   <= rs_val_i;
                        done_q <= 1'b1;
                     end
                     OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        state_q   <= ST_CALC;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        is_div_q  <= op_i[1];
                        div0_q    <= op_i[1] && (rt_val_i == '0);
                        neg_res_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        rs_q      <= rs_val_i;
                        mplier_q  <= b_res;
                        if (op_i[1]) begin
                           acc_q   <= {{WIDTH{1'b0}}, a_res};
                           mcand_q <= {{WIDTH{1'b0}}, b_res};
                        end else begin
                           acc_q   <= '0;
                           mcand_q <= {{WIDTH{1'b0}}, a_res};
                        end
                     end
                     default: ;
                  endcase
               end
            end
            ST_CALC: begin
               if (abort_i) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (is_div_q) begin
                     acc_q <= div_step;
                  end else begin
                     acc_q    <= mul_step;
                     mcand_q  <= mcand_q << 1;
                     mplier_q <= mplier_q >> 1;
                  end
                  if (calc_last)
                     state_q <= ST_FIX;
               end
            end
            ST_FIX: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               if (!abort_i) begin
                  done_q <= 1'b1;
                  if (!is_div_q) begin
                     hi_q <= mul_hi_fix;
                     lo_q <= b_res;
                  end else if (div0_q) begin
                     hi_q <= rs_q;
                     lo_q <= WIDTH'(DIV0_QUOT);
                  end else begin
                     hi_q <= b_res;
                     lo_q <= a_res;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized
// MUL/DIV traffic against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'b000;
   logic [31:0] rs_val = '0, rt_val = '0;
   logic        abort = 1'b0;
   logic        busy, done;
   logic [31:0] hi, lo;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] exp_hi = '0, exp_lo = '0;

   localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010, DIVU = 3'b011;
   localparam logic [2:0] MTHI = 3'b100, MTLO = 3'b101;

   muldiv_unit dut (
      .clk_i    (clk),
      .reset_i  (reset),
      .start_i  (start),
      .op_i     (op),
      .rs_val_i (rs_val),
      .rt_val_i (rt_val),
      .abort_i  (abort),
      .busy_o   (busy),
      .done_o   (done),
      .hi_o     (hi),
      .lo_o     (lo)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Architectural result of one operation
   task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] mh, output logic [31:0] ml);
      longint      sa, sb, sq, sr;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         MULT:  begin p = 64'(sa * sb); mh = p[63:32]; ml = p[31:0]; end
         MULTU: begin p = {32'b0, a} * {32'b0, b}; mh = p[63:32]; ml = p[31:0]; end
         default: begin
            if (b == 0) begin
               mh = a; ml = 32'hFFFF_FFFF;
            end else if (o == DIV) begin
               sq = sa / sb; sr = sa % sb;
               mh = 32'(sr); ml = 32'(sq);
            end else begin
               mh = a % b; ml = a / b;
            end
         end
      endcase
   endtask

   // Cycle index (start edge = cycle 0) at which done is expected
   function automatic int exp_lat(input logic [2:0] o, input logic [31:0] b);
      int msb;
      logic [31:0] m;
`ifdef MULDIV_EARLY_OUT_EN
      if (o == MULT || o == MULTU) begin
         m = (o == MULT && b[31]) ? (32'd0 - b) : b;
         msb = 0;
         for (int i = 0; i < 32; i++) if (m[i]) msb = i;
         return msb + 3;
      end
`else
      m = b; msb = o;
`endif
      return 34;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 255));
         default: return $urandom;
      endcase
   endfunction

   // Issue one MUL/DIV and wait (bounded) for done; reports latency and busy cycles
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_cnt);
      int cyc;
      start = 1'b1; op = o; rs_val = a; rt_val = b;
      tick();
      start = 1'b0;
      cyc = 1; lat = -1; busy_cnt = 0;
      while (lat < 0 && cyc <= 100) begin
         if (done) lat = cyc;
         else begin
            if (busy) busy_cnt++;
            tick();
            cyc++;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick(); tick();
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
      n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL reset_hi got=%h exp=0", hi); end
      n_cmp++; if (lo !== 32'h0) begin n_err++; $display("FAIL reset_lo got=%h exp=0", lo); end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_directed();
      logic [2:0]  ops [6] = '{MULT, MULTU, DIV, DIVU, DIV, MULTU};
      logic [31:0] as  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd5};
      logic [31:0] bs  [6] = '{32'h2, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'hFFFF_FFFF, 32'd3};
      logic [31:0] eh  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h7, 32'h0, 32'h0};
      logic [31:0] el  [6] = '{32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'd15};
      int lat, bc;
      for (int i = 0; i < 6; i++) begin
         run_op(ops[i], as[i], bs[i], lat, bc);
         n_cmp++; if (lat !== exp_lat(ops[i], bs[i])) begin n_err++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, exp_lat(ops[i], bs[i])); end
         n_cmp++; if (hi !== eh[i]) begin n_err++; $display("FAIL dir%0d_hi got=%h exp=%h", i, hi, eh[i]); end
         n_cmp++; if (lo !== el[i]) begin n_err++; $display("FAIL dir%0d_lo got=%h exp=%h", i, lo, el[i]); end
         n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL dir%0d_busy_at_done got=%b exp=0", i, busy); end
         tick();
         n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL dir%0d_done_pulse got=%b exp=0", i, done); end
         exp_hi = eh[i]; exp_lo = el[i];
      end
   endtask

   task automatic test_mthi_mtlo();
      start = 1'b1; op = MTHI; rs_val = 32'h1234_5678;
      tick();
      n_cmp++; if (hi !== 32'h1234_5678) begin n_err++; $display("FAIL mthi_hi got=%h exp=12345678", hi); end
      n_cmp++; if (lo !== exp_lo) begin n_err++; $display("FAIL mthi_lo_hold got=%h exp=%h", lo, exp_lo); end
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL mthi_done got=%b exp=1", done); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mthi_busy got=%b exp=0", busy); end
      op = MTLO; rs_val = 32'h9ABC_DEF0;
      tick();
      start = 1'b0;
      n_cmp++; if (lo !== 32'h9ABC_DEF0) begin n_err++; $display("FAIL mtlo_lo got=%h exp=9abcdef0", lo); end
      n_cmp++; if (hi !== 32'h1234_5678) begin n_err++; $display("FAIL mtlo_hi_hold got=%h exp=12345678", hi); end
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL mtlo_done got=%b exp=1", done); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mtlo_busy got=%b exp=0", busy); end
      tick();
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL mt_done_clear got=%b exp=0", done); end
      exp_hi = 32'h1234_5678; exp_lo = 32'h9ABC_DEF0;
      // Reserved opcode: nothing happens
      start = 1'b1; op = 3'b110; rs_val = 32'hDEAD_BEEF;
      tick();
      start = 1'b0;
      n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL reserved_op got=%b exp=00", {busy, done}); end
      n_cmp++; if (hi !== exp_hi || lo !== exp_lo) begin n_err++; $display("FAIL reserved_hilo got=%h_%h exp=%h_%h", hi, lo, exp_hi, exp_lo); end
   endtask

   task automatic test_abort();
      int done_seen = 0;
      // DIVU 100/3, ignored MULT start at cycle 5, abort at cycle 10
      start = 1'b1; op = DIVU; rs_val = 32'd100; rt_val = 32'd3;
      tick();
      start = 1'b0;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         if (done) done_seen++;
         start = (cyc == 5); op = MULT; rs_val = 32'd9; rt_val = 32'd9;
         abort = (cyc == 10);
         tick();
      end
      start = 1'b0; abort = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_calc_busy got=%b exp=0", busy); end
      for (int k = 0; k < 40; k++) begin
         if (done || busy) done_seen++;
         tick();
      end
      n_cmp++; if (done_seen !== 0) begin n_err++; $display("FAIL abort_calc_activity got=%0d exp=0", done_seen); end
      n_cmp++; if (hi !== exp_hi || lo !== exp_lo) begin n_err++; $display("FAIL abort_calc_hilo got=%h_%h exp=%h_%h", hi, lo, exp_hi, exp_lo); end
      // Abort in FIX (cycle 33 of a divide) beats completion
      start = 1'b1; op = DIV; rs_val = 32'hFFFF_FFF9; rt_val = 32'd2;
      tick();
      start = 1'b0;
      for (int cyc = 1; cyc < 33; cyc++) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL abort_fix_state got=%b exp=00", {busy, done}); end
      n_cmp++; if (hi !== exp_hi || lo !== exp_lo) begin n_err++; $display("FAIL abort_fix_hilo got=%h_%h exp=%h_%h", hi, lo, exp_hi, exp_lo); end
      // Abort in IDLE drops a simultaneous start
      start = 1'b1; abort = 1'b1; op = MTHI; rs_val = 32'h5555_AAAA;
      tick();
      start = 1'b0; abort = 1'b0;
      n_cmp++; if (hi !== exp_hi || done !== 1'b0) begin n_err++; $display("FAIL abort_idle got=%h/%b exp=%h/0", hi, done, exp_hi); end
   endtask

   task automatic test_reset_mid();
      start = 1'b1; op = DIV; rs_val = 32'd1000; rt_val = 32'd7;
      tick();
      start = 1'b0;
      for (int cyc = 1; cyc < 20; cyc++) tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL reset_mid_state got=%b exp=00", {busy, done}); end
      n_cmp++; if (hi !== 32'h0 || lo !== 32'h0) begin n_err++; $display("FAIL reset_mid_hilo got=%h_%h exp=0_0", hi, lo); end
      exp_hi = '0; exp_lo = '0;
      for (int k = 0; k < 40; k++) tick();
      n_cmp++; if (done !== 1'b0 || hi !== 32'h0) begin n_err++; $display("FAIL reset_mid_stale got=%b/%h exp=0/0", done, hi); end
   endtask

   // Back-to-back random MUL/DIV traffic (next start in the done cycle)
   task automatic test_back_to_back();
      logic [2:0]  o;
      logic [31:0] a, b, mh, ml;
      int lat, bc, el;
      for (int i = 0; i < 40; i++) begin
         o = 3'($urandom_range(0, 3));
         a = pick(); b = pick();
         model(o, a, b, mh, ml);
         el = exp_lat(o, b);
         run_op(o, a, b, lat, bc);
         n_cmp++; if (hi !== mh) begin n_err++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got=%h exp=%h", i, o, a, b, hi, mh); end
         n_cmp++; if (lo !== ml) begin n_err++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got=%h exp=%h", i, o, a, b, lo, ml); end
         n_cmp++; if (lat !== el) begin n_err++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, el); end
         n_cmp++; if (bc !== el - 1) begin n_err++; $display("FAIL rnd%0d_busy_cycles got=%0d exp=%0d", i, bc, el - 1); end
         exp_hi = mh; exp_lo = ml;
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_mthi_mtlo();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
